// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings and parity constants.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int S_IDLE  = 0;
  localparam int S_START = 1;
  localparam int S_DATA  = 2;
  localparam int S_PAR   = 3;
  localparam int S_STOP  = 4;
  localparam int S_GAP   = 5;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_START = 6'b000010,
    ST_DATA  = 6'b000100,
    ST_PAR   = 6'b001000,
    ST_STOP  = 6'b010000,
    ST_GAP   = 6'b100000
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic parity_bit(
    input logic [7:0] d,
    input logic       m
  );
    return (^d) ^ (m == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter.
// Pointers carry one extra wrap bit so full/empty need no extra state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic        re,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        empty,
  output logic        full,
  output logic        over,
  output logic [AW:0] level
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_rd;
  logic        do_wr;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign do_rd = re & ~empty;
  assign do_wr = we & (~full | do_rd);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear wins over any same-cycle access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_wr);
      rd_ptr <= rd_ptr + (AW+1)'(do_rd);
    end
  end

  // Sticky overflow: a write to a full FIFO with no pop to make room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      over <= 1'b0;
    else if (clr)
      over <= 1'b0;
    else if (we & full & ~do_rd)
      over <= 1'b1;
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr & ~clr)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO, frame FSM, shift register and parity.
// Optional inter-frame idle gap enabled by UART_TX_GAP_EN.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             Data_i,
  input  logic                   n_We_i,
  input  logic                   n_Clr_i,
  input  logic                   p_Enable_i,
  input  logic                   p_ParityEnable_i,
  input  logic                   p_BigEnd_i,
  input  logic                   ParityMethod_i,
  input  logic                   BaudSig_i,
`ifdef UART_TX_GAP_EN
  input  logic [3:0]             GapBits_i,
`endif
  output logic                   Tx_o,
  output logic                   p_Empty_o,
  output logic                   p_Full_o,
  output logic                   p_Over_o,
  output logic [$clog2(DEPTH):0] TxFifoLevel_o,
  output logic                   p_Busy_o,
  output logic                   p_ByteSent_o
);

  uart_state_e state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [7:0]  shreg;
  logic [7:0]  head;
  logic        par_q, big_q, odd_q;
  logic        tx_n, sent_n, pop;
  logic        avail, go;
`ifdef UART_TX_GAP_EN
  logic [3:0]  gap_cnt, gap_n;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (~n_Clr_i),
    .we    (~n_We_i),
    .re    (pop),
    .wdata (Data_i),
    .rdata (head),
    .empty (p_Empty_o),
    .full  (p_Full_o),
    .over  (p_Over_o),
    .level (TxFifoLevel_o)
  );

  function automatic logic pick(input logic [2:0] c);
    return big_q ? shreg[3'd7 - c] : shreg[c];
  endfunction

  assign avail    = ~p_Empty_o & n_Clr_i;
  assign go       = p_Enable_i & avail;
  assign p_Busy_o = ~state[S_IDLE];

  // Next-state and next line value, evaluated on baud ticks only.
  always_comb begin
    state_n = state;
    tx_n    = Tx_o;
    cnt_n   = cnt;
    sent_n  = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_GAP_EN
    gap_n   = gap_cnt;
`endif
    if (BaudSig_i) begin
      unique case (1'b1)
        state[S_IDLE]: begin
          if (go) begin
            state_n = ST_START;
            tx_n    = 1'b0;
            pop     = 1'b1;
          end
        end
        state[S_START]: begin
          state_n = ST_DATA;
          tx_n    = pick(3'd0);
          cnt_n   = 3'd0;
        end
        state[S_DATA]: begin
          if (cnt == 3'd7) begin
            if (par_q) begin
              state_n = ST_PAR;
              tx_n    = parity_bit(shreg, odd_q);
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            tx_n  = pick(cnt + 3'd1);
            cnt_n = cnt + 3'd1;
          end
        end
        state[S_PAR]: begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end
        state[S_STOP]: begin
          sent_n  = 1'b1;
          tx_n    = 1'b1;
          state_n = ST_IDLE;
`ifdef UART_TX_GAP_EN
          if (GapBits_i != 4'd0) begin
            state_n = ST_GAP;
            gap_n   = GapBits_i;
          end else
`endif
          if (go) begin
            state_n = ST_START;
            tx_n    = 1'b0;
            pop     = 1'b1;
          end
        end
`ifdef UART_TX_GAP_EN
        state[S_GAP]: begin
          tx_n = 1'b1;
          if (gap_cnt <= 4'd1) begin
            state_n = ST_IDLE;
            if (go) begin
              state_n = ST_START;
              tx_n    = 1'b0;
              pop     = 1'b1;
            end
          end else begin
            gap_n = gap_cnt - 4'd1;
          end
        end
`endif
        default: begin
          state_n = ST_IDLE;
          tx_n    = 1'b1;
        end
      endcase
    end
  end

  // State, line, and frame registers; settings latched at pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      Tx_o         <= 1'b1;
      cnt          <= 3'd0;
      p_ByteSent_o <= 1'b0;
      shreg        <= 8'h00;
      par_q        <= 1'b0;
      big_q        <= 1'b0;
      odd_q        <= PARITY_EVEN;
`ifdef UART_TX_GAP_EN
      gap_cnt      <= 4'd0;
`endif
    end else begin
      state        <= state_n;
      Tx_o         <= tx_n;
      cnt          <= cnt_n;
      p_ByteSent_o <= sent_n;
`ifdef UART_TX_GAP_EN
      gap_cnt      <= gap_n;
`endif
      if (pop) begin
        shreg <= head;
        par_q <= p_ParityEnable_i;
        big_q <= p_BigEnd_i;
        odd_q <= ParityMethod_i;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core.
// Baud tick every 16 clk; bits sampled mid-period.
module tb_uart_tx_core;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       n_we = 1'b1;
  logic       n_clr = 1'b1;
  logic       en = 1'b0;
  logic       par_en = 1'b0;
  logic       big = 1'b0;
  logic       meth = PARITY_EVEN;
  logic       baud = 1'b0;
`ifdef UART_TX_GAP_EN
  logic [3:0] gap = 4'd0;
`endif
  logic       tx, empty, full, over, busy, sent;
  logic [4:0] level;

  int total = 0;
  int bad = 0;
  int sent_cnt = 0;
  int base;
  int cyc;
  logic [10:0] fr;

  uart_tx_core #(.DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .Data_i           (data),
    .n_We_i           (n_we),
    .n_Clr_i          (n_clr),
    .p_Enable_i       (en),
    .p_ParityEnable_i (par_en),
    .p_BigEnd_i       (big),
    .ParityMethod_i   (meth),
    .BaudSig_i        (baud),
`ifdef UART_TX_GAP_EN
    .GapBits_i        (gap),
`endif
    .Tx_o             (tx),
    .p_Empty_o        (empty),
    .p_Full_o         (full),
    .p_Over_o         (over),
    .TxFifoLevel_o    (level),
    .p_Busy_o         (busy),
    .p_ByteSent_o     (sent)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (15) @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (sent) sent_cnt <= sent_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    data = b;
    n_we = 1'b0;
    @(negedge clk);
    n_we = 1'b1;
  endtask

  task automatic wait_start(output int c);
    bit found;
    found = 1'b0;
    c = 0;
    while (!found && c < 600) begin
      @(posedge clk);
      #1;
      c++;
      if (tx == 1'b0) found = 1'b1;
    end
    if (!found) chk("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_bits(input int n, output logic [10:0] b);
    b = '0;
    for (int i = 0; i < n; i++) begin
      repeat (i == 0 ? 8 : 16) @(posedge clk);
      #1;
      b[i] = tx;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_over", {31'd0, over}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sent", {31'd0, sent}, 32'd0);

    // LE, no parity, 0x55
    en = 1'b1;
    base = sent_cnt;
    wr(8'h55);
    wait_start(cyc);
    read_bits(10, fr);
    chk("le55_frame", {21'd0, fr}, 32'h2AA);
    repeat (16) @(posedge clk);
    #1;
    chk("le55_sent", sent_cnt - base, 32'd1);
    chk("le55_empty", {31'd0, empty}, 32'd1);
    chk("le55_idle", {31'd0, busy}, 32'd0);

    // BE, even parity, 0xA3
    @(negedge clk);
    big = 1'b1;
    par_en = 1'b1;
    meth = PARITY_EVEN;
    wr(8'hA3);
    wait_start(cyc);
    read_bits(11, fr);
    chk("bea3_frame", {21'd0, fr}, 32'h58A);
    repeat (16) @(posedge clk);

    // Odd parity on 0x00, flip method mid-frame
    @(negedge clk);
    en = 1'b0;
    big = 1'b0;
    meth = PARITY_ODD;
    wr(8'h00);
    wr(8'h00);
    @(negedge clk);
    en = 1'b1;
    wait_start(cyc);
    meth = PARITY_EVEN;
    read_bits(11, fr);
    chk("odd00_frame", {21'd0, fr}, 32'h600);
    wait_start(cyc);
    read_bits(11, fr);
    chk("even00_frame", {21'd0, fr}, 32'h400);
    repeat (16) @(posedge clk);

    // Overflow and clear
    @(negedge clk);
    en = 1'b0;
    par_en = 1'b0;
    for (int i = 0; i < 17; i++) wr(8'(i));
    #1;
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_over", {31'd0, over}, 32'd1);
    @(negedge clk);
    n_clr = 1'b0;
    @(negedge clk);
    n_clr = 1'b1;
    #1;
    chk("clr_level", {27'd0, level}, 32'd0);
    chk("clr_over", {31'd0, over}, 32'd0);
    chk("clr_empty", {31'd0, empty}, 32'd1);
    chk("clr_full", {31'd0, full}, 32'd0);

    // Back-to-back frames
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    chk("b2b_level", {27'd0, level}, 32'd3);
    base = sent_cnt;
    @(negedge clk);
    en = 1'b1;
    wait_start(cyc);
    read_bits(10, fr);
    chk("b2b_f1", {21'd0, fr}, 32'h202);
    wait_start(cyc);
    chk("b2b_gap1", cyc, 32'd8);
    read_bits(10, fr);
    chk("b2b_f2", {21'd0, fr}, 32'h204);
    wait_start(cyc);
    chk("b2b_gap2", cyc, 32'd8);
    read_bits(10, fr);
    chk("b2b_f3", {21'd0, fr}, 32'h206);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_sent", sent_cnt - base, 32'd3);
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Reset during the second of three frames
    @(negedge clk);
    en = 1'b0;
    wr(8'h00);
    wr(8'h00);
    wr(8'h00);
    @(negedge clk);
    en = 1'b1;
    wait_start(cyc);
    read_bits(10, fr);
    wait_start(cyc);
    read_bits(4, fr);
    chk("mid_tx_low", {31'd0, tx}, 32'd0);
    chk("mid_level", {27'd0, level}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_tx", {31'd0, tx}, 32'd1);

`ifdef UART_TX_GAP_EN
    // Idle gap of 3 bit periods between frames
    @(negedge clk);
    en = 1'b0;
    gap = 4'd3;
    wr(8'h01);
    wr(8'h02);
    @(negedge clk);
    en = 1'b1;
    wait_start(cyc);
    read_bits(10, fr);
    chk("gap_f1", {21'd0, fr}, 32'h202);
    wait_start(cyc);
    chk("gap_cycles", cyc, 32'd56);
    read_bits(10, fr);
    chk("gap_f2", {21'd0, fr}, 32'h204);
    repeat (80) @(posedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
